// File: rtl/node_integrator_pkg.sv
// node_integrator_pkg: shared node constants, packed-current slicing and rail clamp
// items: NI_W/NI_HI/NI_LO defaults, cur_lsb(k,w) slice base, sat_clamp(x,hi,lo)
package node_integrator_pkg;

   localparam int NI_W     = 16;
   localparam int NI_HI    = 16384;
   localparam int NI_LO    = -16384;
   localparam int NI_SWMAX = 64;

   // source k of a packed current bus occupies [k*w +: w]
   function automatic int cur_lsb(input int k, input int w);
      return k * w;
   endfunction

   // wide sum saturated to the rails; callers truncate to the node width
   function automatic logic signed [NI_SWMAX-1:0] sat_clamp(
      input logic signed [NI_SWMAX-1:0] x,
      input logic signed [NI_SWMAX-1:0] hi,
      input logic signed [NI_SWMAX-1:0] lo
   );
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/node_integrator_if.sv
// node_integrator_if: current/voltage bundle between device models and a node
// master drives i/force_en/force_val; slave (the node) drives v/p/p_edge/settled
interface node_integrator_if
   import node_integrator_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int W    = NI_W
);

   logic        [N_IN*W-1:0] i;
   logic                     force_en;
   logic                     force_val;
   logic signed [W-1:0]      v;
   logic                     p;
   logic                     p_edge;
   logic                     settled;

   modport master (
      output i, force_en, force_val,
      input  v, p, p_edge, settled
   );

   modport slave (
      input  i, force_en, force_val,
      output v, p, p_edge, settled
   );

endinterface

// File: rtl/node_integrator_level_detect.sv
// node_level_detect: hysteretic logic level of a node voltage plus change pulse
// ports: eclk, erst (sync, high), v in; p level and p_edge pulse out (registered)
module node_level_detect #(
   parameter int W       = 16,
   parameter int HYST    = 1024,
   parameter bit INIT_HI = 1'b0
) (
   input  logic                eclk,
   input  logic                erst,
   input  logic signed [W-1:0] v,
   output logic                p,
   output logic                p_edge
);

   logic r_p;
   logic r_edge;
   logic w_p_next;

   // strict thresholds either side of zero; the band between holds the level
   always_comb begin
      w_p_next = r_p;
      unique case (1'b1)
         (!r_p && (v > HYST)):  w_p_next = 1'b1;
         (r_p && (v < -HYST)):  w_p_next = 1'b0;
         default:               w_p_next = r_p;
      endcase
   end

   always_ff @(posedge eclk) begin
      if (erst) begin
         r_p    <= INIT_HI;
         r_edge <= 1'b0;
      end else begin
         r_p    <= w_p_next;
         r_edge <= (w_p_next != r_p);
      end
   end

   assign p      = r_p;
   assign p_edge = r_edge;

endmodule

// File: rtl/node_integrator.sv
// node_integrator: integrates attached device currents into a saturating node voltage
// ports: eclk, erst (sync, high); bus.slave: i, force_en, force_val -> v, p, p_edge, settled
module node_integrator
   import node_integrator_pkg::*;
#(
   parameter int N_IN          = 4,
   parameter int W             = NI_W,
   parameter int HI            = NI_HI,
   parameter int LO            = NI_LO,
   parameter int HYST          = 2 ** (W - 4),
   parameter int SETTLE_CYCLES = 8,
   parameter bit INIT_HI       = 1'b0
) (
   input  logic             eclk,
   input  logic             erst,
   node_integrator_if.slave bus
);

   // one guard bit per doubling of sources, plus one for v itself
   localparam int SW = W + $clog2(N_IN) + 1;
   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   localparam logic signed [W-1:0] V_HI   = W'(HI);
   localparam logic signed [W-1:0] V_LO   = W'(LO);
   localparam logic        [CW-1:0] C_MAX = CW'(SETTLE_CYCLES);

   logic signed [W-1:0]  r_v;
   logic        [CW-1:0] r_cnt;
   logic                 r_settled;

   logic signed [SW-1:0] w_vn;
   logic signed [W-1:0]  w_v_clamp;
   logic signed [W-1:0]  w_v_next;
   logic        [CW-1:0] w_cnt_next;
   logic                 w_p;
   logic                 w_edge;

   always_comb begin
      w_vn = SW'(r_v);
      for (int k = 0; k < N_IN; k++) begin
         w_vn = w_vn + SW'($signed(bus.i[cur_lsb(k, W) +: W]));
      end
   end

   assign w_v_clamp = W'(sat_clamp(NI_SWMAX'(w_vn),
                                   NI_SWMAX'(HI),
                                   NI_SWMAX'(LO)));

   always_comb begin
      w_v_next = w_v_clamp;
      if (bus.force_en) begin
         w_v_next = bus.force_val ? V_HI : V_LO;
      end
   end

   // a rail-pinned node or a force onto the held rail still counts as still
   always_comb begin
      w_cnt_next = '0;
      if (w_v_next == r_v) begin
         w_cnt_next = (r_cnt == C_MAX) ? r_cnt : r_cnt + CW'(1);
      end
   end

   always_ff @(posedge eclk) begin
      if (erst) begin
         r_v       <= INIT_HI ? V_HI : V_LO;
         r_cnt     <= '0;
         r_settled <= 1'b0;
      end else begin
         r_v       <= w_v_next;
         r_cnt     <= w_cnt_next;
         r_settled <= (w_cnt_next == C_MAX);
      end
   end

   node_level_detect #(
      .W       (W),
      .HYST    (HYST),
      .INIT_HI (INIT_HI)
   ) u_lvl (
      .eclk   (eclk),
      .erst   (erst),
      .v      (r_v),
      .p      (w_p),
      .p_edge (w_edge)
   );

   assign bus.v       = r_v;
   assign bus.p       = w_p;
   assign bus.p_edge  = w_edge;
   assign bus.settled = r_settled;

endmodule

// File: tb/tb_node_integrator.sv
// tb_node_integrator: directed plan then random currents, scoreboard vs node model
// checks v, p, p_edge, settled every cycle one tick after the clock edge
module tb_node_integrator;

   localparam int HI_C   = 16384;
   localparam int LO_C   = -16384;
   localparam int HYST_C = 1024;
   localparam int SET_C  = 4;

   typedef struct {
      int v;
      bit p;
      bit e;
      bit s;
   } exp_t;

   logic eclk;
   logic erst;

   node_integrator_if #(.N_IN(2), .W(16)) nif ();

   node_integrator #(
      .N_IN          (2),
      .W             (16),
      .HI            (HI_C),
      .LO            (LO_C),
      .HYST          (HYST_C),
      .SETTLE_CYCLES (SET_C),
      .INIT_HI       (1'b0)
   ) dut (
      .eclk (eclk),
      .erst (erst),
      .bus  (nif)
   );

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   int m_v   = LO_C;
   bit m_p   = 1'b0;
   int m_cnt = 0;

   initial begin
      eclk = 1'b0;
      forever #5 eclk = ~eclk;
   end

   function automatic int clampi(input int x);
      if (x > HI_C) return HI_C;
      if (x < LO_C) return LO_C;
      return x;
   endfunction

   // one cycle of stimulus; the model says what the node shows after the edge
   task automatic step(input bit rst, input int a, input int b,
                       input bit fe, input bit fv);
      exp_t e;
      int   tgt;
      bit   np;
      @(negedge eclk);
      erst          = rst;
      nif.i         = {16'(b), 16'(a)};
      nif.force_en  = fe;
      nif.force_val = fv;
      if (rst) begin
         m_v   = LO_C;
         m_p   = 1'b0;
         m_cnt = 0;
         e.v = LO_C;
         e.p = 1'b0;
         e.e = 1'b0;
         e.s = 1'b0;
      end else begin
         np = m_p;
         if (!m_p && m_v > HYST_C) np = 1'b1;
         else if (m_p && m_v < -HYST_C) np = 1'b0;
         if (fe) tgt = fv ? HI_C : LO_C;
         else tgt = clampi(m_v + a + b);
         if (tgt == m_v) m_cnt = (m_cnt < SET_C) ? m_cnt + 1 : SET_C;
         else m_cnt = 0;
         e.e = (np != m_p);
         e.p = np;
         e.v = tgt;
         e.s = (m_cnt == SET_C);
         m_p = np;
         m_v = tgt;
      end
      sb.push_back(e);
   endtask

   task automatic run(input int n, input int a, input int b,
                      input bit fe, input bit fv);
      for (int k = 0; k < n; k++) step(1'b0, a, b, fe, fv);
   endtask

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge eclk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if ($isunknown({nif.v, nif.p, nif.p_edge, nif.settled})) begin
               checks++;
               $display("FAIL xstate: outputs unknown at %0t", $time);
            end else begin
               chk("v", int'(nif.v), e.v);
               chk("p", int'(nif.p), int'(e.p));
               chk("edge", int'(nif.p_edge), int'(e.e));
               chk("settled", int'(nif.settled), int'(e.s));
            end
         end
      end
   end

   initial begin
      int a;
      int b;
      int r;
      erst          = 1'b1;
      nif.i         = '0;
      nif.force_en  = 1'b0;
      nif.force_val = 1'b0;

      step(1'b1, 0, 0, 1'b0, 1'b0);
      run(6, 0, 0, 1'b0, 1'b0);
      run(5, 4096, 0, 1'b0, 1'b0);
      run(3, 0, 0, 1'b0, 1'b0);
      run(2, 4096, 0, 1'b0, 1'b0);
      run(6, 8192, 8192, 1'b0, 1'b0);
      run(1, -12288, 0, 1'b0, 1'b0);
      run(1, -4096, 0, 1'b0, 1'b0);
      run(1, -2048, 0, 1'b0, 1'b0);
      run(2, 0, 0, 1'b0, 1'b0);
      run(1, 2048, 0, 1'b0, 1'b0);
      run(6, 8192, 0, 1'b1, 1'b0);
      run(1, 0, 0, 1'b1, 1'b1);
      run(3, 0, 0, 1'b1, 1'b1);
      run(1, 0, 0, 1'b1, 1'b0);
      run(5, 4096, 0, 1'b0, 1'b0);
      run(1, 0, 0, 1'b0, 1'b0);
      step(1'b1, 4096, 4096, 1'b1, 1'b1);
      run(3, 0, 0, 1'b0, 1'b0);
      run(1, 16384, 16384, 1'b0, 1'b0);
      run(3, 0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 25) begin
            a = 0;
            b = 0;
         end else if (r < 65) begin
            a = int'($urandom_range(0, 8192)) - 4096;
            b = int'($urandom_range(0, 8192)) - 4096;
         end else begin
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 65535)) - 32768;
         end
         step(($urandom_range(0, 59) == 0), a, b,
              ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
      end

      for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge eclk);
      #2;
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
